hazard_scoreboard_unit: RTL and testbench

Parametrised successor to the pipeline forwarding unit. It generates forwarding selects for N EX-stage read ports and the ID-stage JALR base register, and the load-use and JALR stalls. It adds a per-register scoreboard for variable-latency writers (LSU miss, divider) and a stall watchdog. It sits beside the ID/EX pipeline registers and drives the operand muxes and the ID/EX stall lines.

---
 rtl/hazard_scoreboard_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Hazard logic that sits beside the ID/EX pipeline registers. It produces:
//   - forwarding selects for NUM_RD_PORTS EX-stage operands (REG / MEM / WB),
//   - the MEM forwarding select for the ID-stage JALR base register,
//   - load-use, JALR and scoreboard stalls (all combinational, zero latency),
//   - a per-register scoreboard for variable-latency writers (LSU miss,
//     divider) whose results retire later through the WB write port,
//   - a sticky watchdog that flags STALL_TIMEOUT consecutive EX stall cycles.
//
// Optional build macro:
//   HAZARD_PERF_CNT_EN  - when defined, adds three 32-bit wrapping event
//                         counters (load-use, scoreboard and JALR stall
//                         cycles). When undefined the perf ports are tied to 0
//                         and no counter flops exist.
//
// Register 0 is hardwired zero: it never forwards, never stalls and never
// becomes pending.
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int ADDR_WIDTH    = 5,
  parameter int NUM_RD_PORTS  = 2,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  // ID stage: JALR base register
  input  logic [ADDR_WIDTH-1:0]            id_raddr_a_i,
  input  logic                             jalr_op_i,
  // EX stage source operands
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] ex_raddr_i,
  input  logic [NUM_RD_PORTS-1:0]          ex_rd_used_i,
  // Destinations in flight
  input  logic [ADDR_WIDTH-1:0]            ex_dest_reg_i,
  input  logic                             ex_reg_we_i,
  input  logic [ADDR_WIDTH-1:0]            mem_dest_reg_i,
  input  logic                             mem_reg_we_i,
  input  logic                             mem_is_load_i,
  input  logic [ADDR_WIDTH-1:0]            wb_dest_reg_i,
  input  logic                             wb_reg_we_i,
  // Variable-latency writers
  input  logic                             lat_issue_i,
  input  logic [ADDR_WIDTH-1:0]            lat_issue_rd_i,
  input  logic                             lat_done_i,
  input  logic [ADDR_WIDTH-1:0]            lat_done_rd_i,
  // Forwarding selects and stalls
  output logic [2*NUM_RD_PORTS-1:0]        ex_fwd_sel_o,
  output logic [1:0]                       jalr_fwd_sel_o,
  output logic                             stall_id_o,
  output logic                             stall_ex_o,
  // Scoreboard and watchdog status
  output logic [2**ADDR_WIDTH-1:0]         pending_o,
  output logic                             timeout_o,
  // Performance counters (tied to 0 unless HAZARD_PERF_CNT_EN)
  output logic [31:0]                      perf_load_use_o,
  output logic [31:0]                      perf_sb_stall_o,
  output logic [31:0]                      perf_jalr_stall_o
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(STALL_TIMEOUT);

  // Operand mux select encoding shared by the EX ports and the JALR base.
  typedef enum logic [1:0] {
    SEL_REG = 2'd0,
    SEL_MEM = 2'd1,
    SEL_WB  = 2'd2
  } fwd_sel_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 timeout_q, timeout_d;

  // ---------------------------------------------------------------------------
  // Combinational hazard terms
  // ---------------------------------------------------------------------------
  logic [2*NUM_RD_PORTS-1:0] ex_fwd_sel;
  logic                      load_use_stall;
  logic                      sb_port_stall;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic                      rd_live;
  logic                      rd_retire;

  logic                      jalr_live;
  logic                      jalr_retire;
  logic [1:0]                jalr_fwd_sel;
  logic                      jalr_stall;
  logic                      sb_jalr_stall;

  logic                      waw_retire;
  logic                      sb_waw_stall;
  logic                      sb_stall;
  logic                      issue_eff;

  // EX operand forwarding selects, load-use and scoreboard read hazards.
  // NOTE: every variable gets a default before the loop, so no path through
  // this block leaves one unassigned and no latch is inferred.
  always_comb begin
    ex_fwd_sel     = '0;
    load_use_stall = 1'b0;
    sb_port_stall  = 1'b0;
    rd_addr        = '0;
    rd_live        = 1'b0;
    rd_retire      = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_addr   = ex_raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_live   = ex_rd_used_i[p] && (rd_addr != '0);
      // A retiring long-latency result is on the WB write port this cycle.
      rd_retire = lat_done_i && (lat_done_rd_i == rd_addr);

      if (rd_live && mem_reg_we_i && !mem_is_load_i && (mem_dest_reg_i == rd_addr)) begin
        ex_fwd_sel[2*p +: 2] = SEL_MEM;
      end else if (rd_live && ((wb_reg_we_i && (wb_dest_reg_i == rd_addr)) ||
                               (pending_q[rd_addr] && rd_retire))) begin
        ex_fwd_sel[2*p +: 2] = SEL_WB;
      end

      // Load data is not available until WB: the consumer must wait a cycle.
      if (rd_live && mem_reg_we_i && mem_is_load_i && (mem_dest_reg_i == rd_addr)) begin
        load_use_stall = 1'b1;
      end

      if (rd_live && pending_q[rd_addr] && !rd_retire) begin
        sb_port_stall = 1'b1;
      end
    end
  end

  // JALR base register: MEM forwarding, EX/load stalls and scoreboard hazard.
  always_comb begin
    jalr_live     = jalr_op_i && (id_raddr_a_i != '0);
    jalr_retire   = lat_done_i && (lat_done_rd_i == id_raddr_a_i);
    jalr_fwd_sel  = SEL_REG;
    jalr_stall    = 1'b0;
    sb_jalr_stall = 1'b0;
    if (jalr_live) begin
      if (mem_reg_we_i && !mem_is_load_i && (mem_dest_reg_i == id_raddr_a_i)) begin
        jalr_fwd_sel = SEL_MEM;
      end
      // The ID-stage target adder cannot take EX results or load data.
      jalr_stall    = (ex_reg_we_i && (ex_dest_reg_i == id_raddr_a_i)) ||
                      (mem_reg_we_i && mem_is_load_i && (mem_dest_reg_i == id_raddr_a_i));
      sb_jalr_stall = pending_q[id_raddr_a_i] && !jalr_retire;
    end
  end

  // Write-after-write against an outstanding long-latency write, then the
  // combined stall lines and the qualified issue.
  always_comb begin
    waw_retire   = lat_done_i && (lat_done_rd_i == ex_dest_reg_i);
    sb_waw_stall = ex_reg_we_i && (ex_dest_reg_i != '0) &&
                   pending_q[ex_dest_reg_i] && !waw_retire;
    sb_stall     = sb_port_stall || sb_jalr_stall || sb_waw_stall;
    stall_ex_o   = load_use_stall || sb_stall;
    stall_id_o   = stall_ex_o || jalr_stall;
    // An issue while EX is held is the same instruction again next cycle.
    issue_eff    = lat_issue_i && !stall_ex_o && (lat_issue_rd_i != '0);
  end

  assign ex_fwd_sel_o   = ex_fwd_sel;
  assign jalr_fwd_sel_o = jalr_fwd_sel;

  // ---------------------------------------------------------------------------
  // Scoreboard: clear on completion first, then set on issue, so a same-cycle
  // issue and done on one register leaves it pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    if (lat_done_i) begin
      pending_d[lat_done_rd_i] = 1'b0;
    end
    if (issue_eff) begin
      pending_d[lat_issue_rd_i] = 1'b1;
    end
  end

  // Scoreboard register.
  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples its inputs from the same pre-edge values.
  // NOTE: pending is a small flop vector rather than a RAM, so it is reset
  // directly; an abandoned long-latency write must not leave a stale bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

  // ---------------------------------------------------------------------------
  // Watchdog: consecutive stall_ex_o cycles, saturating; the flag is raised in
  // the same edge that brings the count to STALL_TIMEOUT and then sticks.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!stall_ex_o) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q == CNT_MAX) begin
      stall_cnt_d = CNT_MAX;
    end else begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    timeout_d = timeout_q || (stall_cnt_d == TIMEOUT_VAL);
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters. Several causes in one cycle bump each
  // matching counter.
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_use_q;
  logic [31:0] perf_sb_stall_q;
  logic [31:0] perf_jalr_stall_q;

  // Wrapping event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_load_use_q   <= '0;
      perf_sb_stall_q   <= '0;
      perf_jalr_stall_q <= '0;
    end else begin
      if (load_use_stall) perf_load_use_q   <= perf_load_use_q + 32'd1;
      if (sb_stall)       perf_sb_stall_q   <= perf_sb_stall_q + 32'd1;
      if (jalr_stall)     perf_jalr_stall_q <= perf_jalr_stall_q + 32'd1;
    end
  end

  assign perf_load_use_o   = perf_load_use_q;
  assign perf_sb_stall_o   = perf_sb_stall_q;
  assign perf_jalr_stall_o = perf_jalr_stall_q;
`else
  assign perf_load_use_o   = '0;
  assign perf_sb_stall_o   = '0;
  assign perf_jalr_stall_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_scoreboard_unit (ADDR_WIDTH=5, 2 ports, STALL_TIMEOUT=4).
// Directed scenarios with hand-derived expectations, then randomized traffic
// checked against a behavioural model: a pending-register array, a run-length
// of stall cycles and event tallies, evaluated from the hazard rules directly.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

  localparam int AW = 5;
  localparam int NP = 2;
  localparam int TO = 4;
  localparam int CW = 16;
  localparam int NR = 32;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [AW-1:0]   id_raddr;
  logic            jalr_op;
  logic [NP*AW-1:0] ex_raddr;
  logic [NP-1:0]   ex_used;
  logic [AW-1:0]   ex_dest;
  logic            ex_we;
  logic [AW-1:0]   mem_dest;
  logic            mem_we;
  logic            mem_load;
  logic [AW-1:0]   wb_dest;
  logic            wb_we;
  logic            lat_issue;
  logic [AW-1:0]   lat_issue_rd;
  logic            lat_done;
  logic [AW-1:0]   lat_done_rd;

  logic [2*NP-1:0] ex_fwd_sel;
  logic [1:0]      jalr_sel;
  logic            stall_id;
  logic            stall_ex;
  logic [NR-1:0]   pending;
  logic            timeout;
  logic [31:0]     perf_lu;
  logic [31:0]     perf_sb;
  logic [31:0]     perf_js;

  // {sel1, sel0, jalr_sel, stall_id, stall_ex}
  logic [7:0] obs;
  assign obs = {ex_fwd_sel, jalr_sel, stall_id, stall_ex};

  int checks = 0;
  int errors = 0;

  hazard_scoreboard_unit #(
    .ADDR_WIDTH   (AW),
    .NUM_RD_PORTS (NP),
    .STALL_TIMEOUT(TO),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .id_raddr_a_i     (id_raddr),
    .jalr_op_i        (jalr_op),
    .ex_raddr_i       (ex_raddr),
    .ex_rd_used_i     (ex_used),
    .ex_dest_reg_i    (ex_dest),
    .ex_reg_we_i      (ex_we),
    .mem_dest_reg_i   (mem_dest),
    .mem_reg_we_i     (mem_we),
    .mem_is_load_i    (mem_load),
    .wb_dest_reg_i    (wb_dest),
    .wb_reg_we_i      (wb_we),
    .lat_issue_i      (lat_issue),
    .lat_issue_rd_i   (lat_issue_rd),
    .lat_done_i       (lat_done),
    .lat_done_rd_i    (lat_done_rd),
    .ex_fwd_sel_o     (ex_fwd_sel),
    .jalr_fwd_sel_o   (jalr_sel),
    .stall_id_o       (stall_id),
    .stall_ex_o       (stall_ex),
    .pending_o        (pending),
    .timeout_o        (timeout),
    .perf_load_use_o  (perf_lu),
    .perf_sb_stall_o  (perf_sb),
    .perf_jalr_stall_o(perf_js)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit          pend_m [NR];
  int unsigned run_m;
  bit          tmo_m;
  int unsigned plu_m, psb_m, pjs_m;

  typedef struct packed {
    logic [7:0] obs;
    logic       lu;
    logic       sb;
    logic       js;
  } exp_t;

  function automatic exp_t predict();
    exp_t       e;
    logic [1:0] sel [NP];
    logic [1:0] jsel;
    bit         lu, sb, js;
    int         a;
    bit         live, retire;
    lu = 0; sb = 0; js = 0; jsel = 2'd0;
    for (int p = 0; p < NP; p++) begin
      a      = int'(ex_raddr[p*AW +: AW]);
      live   = ex_used[p] && (a != 0);
      retire = lat_done && (int'(lat_done_rd) == a);
      sel[p] = 2'd0;
      if (live && mem_we && !mem_load && int'(mem_dest) == a)
        sel[p] = 2'd1;
      else if (live && ((wb_we && int'(wb_dest) == a) || (pend_m[a] && retire)))
        sel[p] = 2'd2;
      if (live && mem_we && mem_load && int'(mem_dest) == a) lu = 1;
      if (live && pend_m[a] && !retire) sb = 1;
    end
    if (jalr_op && id_raddr != 0) begin
      if (mem_we && !mem_load && mem_dest == id_raddr) jsel = 2'd1;
      if ((ex_we && ex_dest == id_raddr) || (mem_we && mem_load && mem_dest == id_raddr)) js = 1;
      if (pend_m[id_raddr] && !(lat_done && lat_done_rd == id_raddr)) sb = 1;
    end
    if (ex_we && ex_dest != 0 && pend_m[ex_dest] && !(lat_done && lat_done_rd == ex_dest)) sb = 1;
    e.obs = {sel[1], sel[0], jsel, (lu | js | sb), (lu | sb)};
    e.lu  = lu;
    e.sb  = sb;
    e.js  = js;
    return e;
  endfunction

  function automatic logic [NR-1:0] pend_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = pend_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) pend_m[i] = 0;
    run_m = 0; tmo_m = 0; plu_m = 0; psb_m = 0; pjs_m = 0;
  endtask

  // Advance one clock; the model consumes the inputs seen at this edge.
  task automatic tick();
    exp_t e;
    e = predict();
    if (lat_done) pend_m[lat_done_rd] = 0;
    if (lat_issue && !e.obs[0] && lat_issue_rd != 0) pend_m[lat_issue_rd] = 1;
    if (e.obs[0]) run_m = (run_m < (1 << CW) - 1) ? run_m + 1 : run_m;
    else          run_m = 0;
    if (run_m >= TO) tmo_m = 1;
    if (e.lu) plu_m++;
    if (e.sb) psb_m++;
    if (e.js) pjs_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_raddr = '0; jalr_op = 0; ex_raddr = '0; ex_used = '0;
    ex_dest = '0; ex_we = 0; mem_dest = '0; mem_we = 0; mem_load = 0;
    wb_dest = '0; wb_we = 0; lat_issue = 0; lat_issue_rd = '0;
    lat_done = 0; lat_done_rd = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #3;
    checks++;
    if (obs !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %h want 00", obs);
    end
    checks++;
    if (pending !== '0 || timeout !== 1'b0) begin
      errors++; $display("FAIL reset_state: pending %h timeout %b want 0 0", pending, timeout);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    idle();
    mem_dest = 5; mem_we = 1; wb_dest = 5; wb_we = 1;
    ex_raddr = {5'd0, 5'd5}; ex_used = 2'b01;
    #2;
    checks++;
    if (obs !== 8'h10) begin
      errors++; $display("FAIL fwd_mem_priority: got %h want 10", obs);
    end
    mem_we = 0;
    #1;
    checks++;
    if (obs !== 8'h20) begin
      errors++; $display("FAIL fwd_wb: got %h want 20", obs);
    end
    mem_we = 1; mem_dest = 0; wb_dest = 0; ex_raddr = '0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++; $display("FAIL fwd_x0: got %h want 00", obs);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    mem_we = 1; mem_load = 1; mem_dest = 7;
    ex_raddr = {5'd7, 5'd0}; ex_used = 2'b10;
    #2;
    checks++;
    if (obs !== 8'h03) begin
      errors++; $display("FAIL load_use_stall: got %h want 03", obs);
    end
    tick();
    mem_we = 0; mem_load = 0; wb_dest = 7; wb_we = 1;
    #2;
    checks++;
    if (obs !== 8'h80) begin
      errors++; $display("FAIL load_use_wb_fwd: got %h want 80", obs);
    end
    tick();
  endtask

  task automatic test_jalr();
    idle();
    jalr_op = 1; id_raddr = 3; ex_dest = 3; ex_we = 1;
    #2;
    checks++;
    if (obs !== 8'h02) begin
      errors++; $display("FAIL jalr_ex_stall: got %h want 02", obs);
    end
    tick();
    ex_we = 0; mem_dest = 3; mem_we = 1;
    #2;
    checks++;
    if (obs !== 8'h04) begin
      errors++; $display("FAIL jalr_mem_fwd: got %h want 04", obs);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    lat_issue = 1; lat_issue_rd = 9;
    tick();
    lat_issue = 0;
    #2;
    checks++;
    if (pending !== 32'h0000_0200) begin
      errors++; $display("FAIL sb_issue: pending %h want 00000200", pending);
    end
    ex_raddr = {5'd0, 5'd9}; ex_used = 2'b01;
    #1;
    checks++;
    if (obs !== 8'h03) begin
      errors++; $display("FAIL sb_read_stall: got %h want 03", obs);
    end
    tick();
    lat_done = 1; lat_done_rd = 9; wb_dest = 9; wb_we = 1;
    #2;
    checks++;
    if (obs !== 8'h20) begin
      errors++; $display("FAIL sb_retire_bypass: got %h want 20", obs);
    end
    tick();
    idle();
    #2;
    checks++;
    if (pending !== '0) begin
      errors++; $display("FAIL sb_retire_clear: pending %h want 0", pending);
    end
    // Re-issue, then issue and complete x9 in the same cycle.
    lat_issue = 1; lat_issue_rd = 9;
    tick();
    lat_done = 1; lat_done_rd = 9;
    tick();
    idle();
    #2;
    checks++;
    if (pending !== 32'h0000_0200) begin
      errors++; $display("FAIL sb_issue_and_done: pending %h want 00000200", pending);
    end
    lat_done = 1; lat_done_rd = 9;
    tick();
    idle();
    lat_issue = 1; lat_issue_rd = 0;
    tick();
    idle();
    #2;
    checks++;
    if (pending !== '0) begin
      errors++; $display("FAIL sb_issue_x0: pending %h want 0", pending);
    end
  endtask

  task automatic test_waw();
    idle();
    lat_issue = 1; lat_issue_rd = 4;
    tick();
    idle();
    ex_dest = 4; ex_we = 1; lat_issue = 1; lat_issue_rd = 12;
    #2;
    checks++;
    if (obs !== 8'h03) begin
      errors++; $display("FAIL waw_stall: got %h want 03", obs);
    end
    tick();
    idle();
    #2;
    checks++;
    if (pending !== 32'h0000_0010) begin
      errors++; $display("FAIL issue_during_stall: pending %h want 00000010", pending);
    end
    lat_done = 1; lat_done_rd = 4;
    tick();
    idle();
    tick();
  endtask

  task automatic test_watchdog();
    idle();
    lat_issue = 1; lat_issue_rd = 9;
    tick();
    idle();
    ex_raddr = {5'd0, 5'd9}; ex_used = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      #2;
      checks++;
      if (stall_ex !== 1'b1 || timeout !== (i >= 5)) begin
        errors++;
        $display("FAIL watchdog_cycle%0d: stall %b timeout %b want 1 %b", i, stall_ex, timeout, (i >= 5));
      end
      tick();
    end
    ex_used = 2'b00;
    tick();
    #2;
    checks++;
    if (timeout !== 1'b1 || stall_ex !== 1'b0) begin
      errors++; $display("FAIL watchdog_sticky: timeout %b stall %b want 1 0", timeout, stall_ex);
    end
  endtask

  task automatic test_async_reset();
    ex_used = 2'b01;
    #1;
    checks++;
    if (stall_ex !== 1'b1) begin
      errors++; $display("FAIL pre_reset_stall: got %b want 1", stall_ex);
    end
    rst_ni = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pending !== '0 || timeout !== 1'b0 || stall_ex !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pending %h timeout %b stall %b want 0 0 0", pending, timeout, stall_ex);
    end
    #1;
    rst_ni = 1'b1;
    idle();
    lat_done = 1; lat_done_rd = 9;
    tick();
    idle();
    #2;
    checks++;
    if (pending !== '0) begin
      errors++; $display("FAIL done_after_reset: pending %h want 0", pending);
    end
    tick();
  endtask

  task automatic test_random();
    exp_t e;
    logic [95:0] perf_exp;
    for (int i = 0; i < 600; i++) begin
      jalr_op      = ($urandom_range(0, 3) == 0);
      id_raddr     = 5'($urandom_range(0, 7));
      ex_raddr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_used      = 2'($urandom_range(0, 3));
      ex_dest      = 5'($urandom_range(0, 7));
      ex_we        = ($urandom_range(0, 2) == 0);
      mem_dest     = 5'($urandom_range(0, 7));
      mem_we       = ($urandom_range(0, 1) == 0);
      mem_load     = ($urandom_range(0, 2) == 0);
      wb_dest      = 5'($urandom_range(0, 7));
      wb_we        = ($urandom_range(0, 1) == 0);
      lat_issue    = ($urandom_range(0, 3) == 0);
      lat_issue_rd = 5'($urandom_range(0, 7));
      lat_done     = ($urandom_range(0, 1) == 0);
      lat_done_rd  = 5'($urandom_range(0, 7));
      #2;
      e = predict();
      checks++;
      if (obs !== e.obs) begin
        errors++; $display("FAIL rand_comb[%0d]: got %h want %h", i, obs, e.obs);
      end
      checks++;
      if (pending !== pend_vec() || timeout !== tmo_m) begin
        errors++;
        $display("FAIL rand_state[%0d]: pending %h timeout %b want %h %b", i, pending, timeout, pend_vec(), tmo_m);
      end
`ifdef HAZARD_PERF_CNT_EN
      perf_exp = {plu_m, psb_m, pjs_m};
`else
      perf_exp = '0;
`endif
      checks++;
      if ({perf_lu, perf_sb, perf_js} !== perf_exp) begin
        errors++;
        $display("FAIL rand_perf[%0d]: got %0d %0d %0d want %0d %0d %0d", i, perf_lu, perf_sb, perf_js,
                 perf_exp[95:64], perf_exp[63:32], perf_exp[31:0]);
      end
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    model_reset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_jalr();
    test_scoreboard();
    test_waw();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on simulation time.
  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: run did not end, checks %0d", checks);
    $fatal(1);
  end

endmodule
